// File: rtl/opl3_pkg.sv
// Shared types and constants for the synth audio path.
// Holds the default sample width and the I2S receiver FSM states.
package opl3_pkg;

  localparam int SAMPLE_WIDTH = 16;

  typedef enum logic [1:0] {
    HUNT  = 2'd0,
    LEFT  = 2'd1,
    RIGHT = 2'd2
  } i2s_rx_state_t;

endpackage

// File: rtl/synchronizer.sv
// Multi-bit flop-chain synchronizer for slow asynchronous inputs.
// Each bit is synchronized independently; equal depth keeps relative skew.
module synchronizer #(
  parameter int WIDTH  = 1,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [STAGES-1:0][WIDTH-1:0] sync_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], d_i};
    end
  end

  assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/i2s_rx.sv
// Philips I2S receiver: oversamples sclk in the clk domain and
// delivers signed left/right pairs with a one-cycle valid pulse.
module i2s_rx #(
  parameter int SAMPLE_WIDTH = opl3_pkg::SAMPLE_WIDTH,
  parameter int SYNC_STAGES  = 2
) (
  input  logic                           clk,
  input  logic                           reset_n,
  input  logic                           i2s_sclk,
  input  logic                           i2s_ws,
  input  logic                           i2s_sd,
  output logic signed [SAMPLE_WIDTH-1:0] left_channel,
  output logic signed [SAMPLE_WIDTH-1:0] right_channel,
  output logic                           sample_valid,
  output logic                           word_err
);

  import opl3_pkg::*;

  localparam int SW = SAMPLE_WIDTH;
  localparam int CW = $clog2(SW + 3);
  localparam logic [CW-1:0] CNT_FULL = CW'(SW);
  localparam logic [CW-1:0] CNT_SAT  = CW'(SW + 1);

  logic [2:0] sync_s;
  logic       sclk_s, ws_s, sd_s;

  synchronizer #(
    .WIDTH  (3),
    .STAGES (SYNC_STAGES)
  ) u_sync (
    .clk     (clk),
    .reset_n (reset_n),
    .d_i     ({i2s_sclk, i2s_ws, i2s_sd}),
    .q_o     (sync_s)
  );

  assign {sclk_s, ws_s, sd_s} = sync_s;

  i2s_rx_state_t state_q, state_d;
  logic          sclk_prev_q;
  logic          ws_prev_q, ws_prev_d;
  logic [CW-1:0] bit_cnt_q, bit_cnt_d;
  logic [SW-1:0] shreg_q, shreg_d;
  logic [SW-1:0] hold_q, hold_d;
  logic [SW-1:0] left_q, left_d;
  logic [SW-1:0] right_q, right_d;
  logic          valid_q, valid_d;
  logic          err_q, err_d;

  logic          rise, boundary;
  logic [SW-1:0] shreg_sh, word;
  logic [CW-1:0] nbits;
  logic          word_bad;

  assign rise     = sclk_s & ~sclk_prev_q;
  assign boundary = rise & (ws_s != ws_prev_q);

  // The boundary bit is the LSB of the ending word, so fold it in first.
  always_comb begin
    shreg_sh = shreg_q;
    if (bit_cnt_q < CNT_FULL) begin
      shreg_sh = {shreg_q[SW-2:0], sd_s};
    end
    nbits    = bit_cnt_q + 1'b1;
    word_bad = (nbits != CNT_FULL);
    word     = shreg_sh;
    if (nbits < CNT_FULL) begin
      word = shreg_sh << (CNT_FULL - nbits);
    end
  end

  always_comb begin
    state_d   = state_q;
    ws_prev_d = ws_prev_q;
    bit_cnt_d = bit_cnt_q;
    shreg_d   = shreg_q;
    hold_d    = hold_q;
    left_d    = left_q;
    right_d   = right_q;
    valid_d   = 1'b0;
    err_d     = err_q;
    if (rise) begin
      ws_prev_d = ws_s;
      if (boundary) begin
        bit_cnt_d = '0;
        shreg_d   = '0;
        unique case (state_q)
          HUNT: begin
            if (!ws_s) state_d = LEFT;
          end
          LEFT: begin
            state_d = RIGHT;
            hold_d  = word;
            err_d   = err_q | word_bad;
          end
          RIGHT: begin
            state_d = LEFT;
            left_d  = hold_q;
            right_d = word;
            valid_d = 1'b1;
            err_d   = err_q | word_bad;
          end
          default: state_d = HUNT;
        endcase
      end else begin
        shreg_d = shreg_sh;
        if (bit_cnt_q != CNT_SAT) bit_cnt_d = bit_cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= HUNT;
      sclk_prev_q <= 1'b0;
      ws_prev_q   <= 1'b0;
      bit_cnt_q   <= '0;
      shreg_q     <= '0;
      hold_q      <= '0;
      left_q      <= '0;
      right_q     <= '0;
      valid_q     <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      sclk_prev_q <= sclk_s;
      ws_prev_q   <= ws_prev_d;
      bit_cnt_q   <= bit_cnt_d;
      shreg_q     <= shreg_d;
      hold_q      <= hold_d;
      left_q      <= left_d;
      right_q     <= right_d;
      valid_q     <= valid_d;
      err_q       <= err_d;
    end
  end

  assign left_channel  = left_q;
  assign right_channel = right_q;
  assign sample_valid  = valid_q;
  assign word_err      = err_q;

endmodule

// File: tb/tb_i2s_rx.sv
// Directed bench for i2s_rx: drives a Philips I2S stream and
// checks captured pairs, error flag and reset behaviour.
module tb_i2s_rx;

  logic               clk = 1'b0;
  logic               reset_n = 1'b0;
  logic               i2s_sclk = 1'b0;
  logic               i2s_ws = 1'b0;
  logic               i2s_sd = 1'b0;
  logic signed [15:0] left_channel;
  logic signed [15:0] right_channel;
  logic               sample_valid;
  logic               word_err;

  i2s_rx dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .i2s_sclk      (i2s_sclk),
    .i2s_ws        (i2s_ws),
    .i2s_sd        (i2s_sd),
    .left_channel  (left_channel),
    .right_channel (right_channel),
    .sample_valid  (sample_valid),
    .word_err      (word_err)
  );

  always #5 clk = ~clk;

  int          n_chk = 0;
  int          n_err = 0;
  int          wide  = 0;
  logic        prev_v = 1'b0;
  logic        pend = 1'b0;
  logic [15:0] ql[$];
  logic [15:0] qr[$];

  always @(negedge clk) begin
    if (sample_valid) begin
      ql.push_back(left_channel);
      qr.push_back(right_channel);
      if (prev_v) wide++;
    end
    prev_v = sample_valid;
  end

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d (0x%0h) want %0d (0x%0h)",
               tag, got, got, exp, exp);
    end
  endtask

  // One sclk period; sd carries the bit queued by the previous slot.
  task automatic slot(input logic w, input logic d);
    i2s_sclk = 1'b0;
    i2s_ws   = w;
    i2s_sd   = pend;
    pend     = d;
    #40;
    i2s_sclk = 1'b1;
    #40;
  endtask

  task automatic frame(input int n, input logic [31:0] l,
                       input logic [31:0] r);
    for (int i = n - 1; i >= 0; i--) slot(1'b0, l[i]);
    for (int i = n - 1; i >= 0; i--) slot(1'b1, r[i]);
  endtask

  task automatic do_reset();
    i2s_sclk = 1'b0;
    i2s_ws   = 1'b0;
    i2s_sd   = 1'b0;
    pend     = 1'b0;
    reset_n  = 1'b0;
    repeat (4) @(posedge clk);
    #3 reset_n = 1'b1;
    repeat (4) @(posedge clk);
    #3;
    ql.delete();
    qr.delete();
  endtask

  task automatic pair(input string tag, input int l, input int r);
    chk({tag, "_have"}, int'(ql.size() > 0), 1);
    if (ql.size() > 0) begin
      chk({tag, "_L"}, int'(ql.pop_front()), l);
      chk({tag, "_R"}, int'(qr.pop_front()), r);
    end
  endtask

  task automatic spair(input string tag, input int l, input int r);
    logic signed [15:0] sl, sr;
    chk({tag, "_have"}, int'(ql.size() > 0), 1);
    if (ql.size() > 0) begin
      sl = ql.pop_front();
      sr = qr.pop_front();
      chk({tag, "_Ls"}, int'(sl), l);
      chk({tag, "_Rs"}, int'(sr), r);
    end
  endtask

  initial begin
    reset_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_L", int'($unsigned(left_channel)), 0);
    chk("rst_R", int'($unsigned(right_channel)), 0);
    chk("rst_V", int'(sample_valid), 0);
    chk("rst_E", int'(word_err), 0);

    // Loopback: first frame discarded, one pulse per frame after.
    do_reset();
    frame(16, 'h1234, 'hABCD);
    chk("A_hunt", ql.size(), 0);
    frame(16, 'h1234, 'hABCD);
    frame(16, 'h1234, 'hABCD);
    frame(16, 'h0000, 'h0000);
    chk("A_cnt", ql.size(), 2);
    pair("A1", 'h1234, 'hABCD);
    pair("A2", 'h1234, 'hABCD);
    chk("A_err", int'(word_err), 0);

    // Full-scale signed extremes.
    do_reset();
    frame(16, 'h0000, 'h0000);
    frame(16, 'h8000, 'h7FFF);
    frame(16, 'hFFFF, 'h0001);
    frame(16, 'h0000, 'h0000);
    chk("B_cnt", ql.size(), 2);
    spair("B1", -32768, 32767);
    spair("B2", -1, 1);
    chk("B_err", int'(word_err), 0);

    // 18-bit words are truncated to the top 16 bits.
    do_reset();
    frame(18, 'h2AAAB, 'h2AAAB);
    chk("C_err0", int'(word_err), 0);
    frame(18, 'h2AAAB, 'h2AAAB);
    frame(16, 'h0000, 'h0000);
    chk("C_cnt", ql.size(), 1);
    pair("C1", 'hAAAA, 'hAAAA);
    chk("C_err", int'(word_err), 1);

    // 12-bit words are left-justified.
    do_reset();
    frame(12, 'hABC, 'h123);
    frame(12, 'hABC, 'h123);
    frame(16, 'h0000, 'h0000);
    chk("D_cnt", ql.size(), 1);
    pair("D1", 'hABC0, 'h1230);
    chk("D_err", int'(word_err), 1);

    // Stream starts mid right word with garbage.
    do_reset();
    for (int i = 0; i < 7; i++) slot(1'b1, 1'($urandom));
    chk("E_none", ql.size(), 0);
    frame(16, 'h5A5A, 'hC3C3);
    frame(16, 'h0000, 'h0000);
    chk("E_cnt", ql.size(), 1);
    pair("E1", 'h5A5A, 'hC3C3);
    chk("E_err", int'(word_err), 0);

    // Reset mid left word.
    do_reset();
    frame(16, 'h1111, 'h2222);
    frame(16, 'h3333, 'h4444);
    for (int i = 15; i >= 11; i--) slot(1'b0, 1'(16'h5555 >> i));
    pair("F0", 'h3333, 'h4444);
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    chk("F_rst_L", int'($unsigned(left_channel)), 0);
    chk("F_rst_R", int'($unsigned(right_channel)), 0);
    chk("F_rst_V", int'(sample_valid), 0);
    repeat (3) @(posedge clk);
    #3 reset_n = 1'b1;
    for (int i = 10; i >= 0; i--) slot(1'b0, 1'(16'h5555 >> i));
    for (int i = 15; i >= 0; i--) slot(1'b1, 1'(16'hAAAA >> i));
    chk("F_hunt", ql.size(), 0);
    frame(16, 'h6666, 'h7777);
    frame(16, 'h8888, 'h9999);
    frame(16, 'h0000, 'h0000);
    chk("F_cnt", ql.size(), 2);
    pair("F1", 'h6666, 'h7777);
    pair("F2", 'h8888, 'h9999);
    chk("F_err", int'(word_err), 0);

    chk("pulse_width", wide, 0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
